// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//
// Bundles the three request/response channels that meet at the memory
// arbiter: the I-cache refill port, the D-cache refill/writeback port and
// the off-chip memory request channel.
//
// Parameters:
//   AWIDTH  byte address width
//   DWIDTH  memory beat/line width
//   MWIDTH  write byte-mask width (DWIDTH/8)
//
// Modports:
//   slave   the arbiter's view: cache requests and memory responses come in,
//           cache ready/responses and memory requests go out
//   master  the surrounding system's view (caches + memory model)

interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 128,
    parameter int MWIDTH = 16
);
    // I-cache port (read only)
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [AWIDTH-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DWIDTH-1:0] ic_resp_data;

    // D-cache port (read or write)
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [AWIDTH-1:0] dc_req_addr;
    logic [DWIDTH-1:0] dc_req_wdata;
    logic [MWIDTH-1:0] dc_req_wmask;
    logic              dc_resp_valid;
    logic [DWIDTH-1:0] dc_resp_data;

    // Memory channel
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [AWIDTH-1:0] mem_req_addr;
    logic [DWIDTH-1:0] mem_req_wdata;
    logic [MWIDTH-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DWIDTH-1:0] mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single main-memory request channel between the I-cache refill
// port and the D-cache refill/writeback port. One transaction is in flight
// at a time; read data is returned only to the port that issued the read.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-low
//   bus    mem_arbiter_if.slave: I-cache, D-cache and memory channels
//   busy   high whenever the FSM is not IDLE
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin on ties, pointer flips
//                                        to the other port after each grant
//                           undefined -> fixed priority, D-cache wins ties
//
// All outputs come from registers or the state bits. The request-ready
// pulse is therefore registered: the grant is decided one cycle ahead
// (whenever the FSM is about to be IDLE) and the pulse appears while the
// FSM sits in IDLE. The handshake only completes if the requester still
// holds valid during that pulse, so a requester that drops valid early is
// never granted.

module mem_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 128,
    parameter int MWIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q;      // 0 = I-cache, 1 = D-cache
    logic              rw_q;
    logic              ic_ready_q, dc_ready_q;
    logic              ic_ready_d, dc_ready_d;
    logic              grant_ic, grant_dc;
    logic              take_ic, take_dc;
    logic              in_issue, in_resp;

    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [MWIDTH-1:0] wmask_q;
    logic [DWIDTH-1:0] rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              rr_ptr_q;     // 0 = I-cache favoured on the next tie
`endif

    // A handshake is the registered ready pulse meeting a still-valid request.
    assign take_ic = ic_ready_q & bus.ic_req_valid;
    assign take_dc = dc_ready_q & bus.dc_req_valid;

    // Tie-break between the two ports.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (bus.ic_req_valid && bus.dc_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_ic = ~rr_ptr_q;
            grant_dc = rr_ptr_q;
`else
            grant_dc = 1'b1;
`endif
        end else begin
            grant_ic = bus.ic_req_valid;
            grant_dc = bus.dc_req_valid;
        end
    end

    // Next state, plus the look-ahead ready pulse for the coming IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take_ic || take_dc) state_d = S_ISSUE;
            S_ISSUE: if (bus.mem_req_ready)  state_d = rw_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (bus.mem_resp_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ic_ready_d = (state_d == S_IDLE) && grant_ic;
        dc_ready_d = (state_d == S_IDLE) && grant_dc;
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rw_q       <= 1'b0;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ic_ready_q <= ic_ready_d;
            dc_ready_q <= dc_ready_d;
            if (take_ic || take_dc) begin
                owner_q <= take_dc;
                rw_q    <= take_dc & bus.dc_req_rw;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Point at the port that did not just win.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else if (take_ic || take_dc) begin
            rr_ptr_q <= take_ic;
        end
    end
`endif

    // Data capture. These registers are only visible through state-gated
    // outputs, so they need no reset.
    always_ff @(posedge clk) begin
        if (take_ic) begin
            addr_q  <= bus.ic_req_addr;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (take_dc) begin
            addr_q  <= bus.dc_req_addr;
            wdata_q <= bus.dc_req_wdata;
            wmask_q <= bus.dc_req_wmask;
        end
        if ((state_q == S_WAIT) && bus.mem_resp_valid) begin
            rdata_q <= bus.mem_resp_data;
        end
    end

    assign in_issue = (state_q == S_ISSUE);
    assign in_resp  = (state_q == S_RESP);

    assign bus.ic_req_ready  = ic_ready_q;
    assign bus.dc_req_ready  = dc_ready_q;

    assign bus.mem_req_valid = in_issue;
    assign bus.mem_req_rw    = in_issue & rw_q;
    assign bus.mem_req_addr  = in_issue ? addr_q  : '0;
    assign bus.mem_req_wdata = in_issue ? wdata_q : '0;
    assign bus.mem_req_wmask = in_issue ? wmask_q : '0;

    assign bus.ic_resp_valid = in_resp & ~owner_q;
    assign bus.dc_resp_valid = in_resp &  owner_q;
    assign bus.ic_resp_data  = in_resp ? rdata_q : '0;
    assign bus.dc_resp_data  = in_resp ? rdata_q : '0;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Inputs are driven and outputs sampled
// 1 ns after each rising edge. Build with or without MEM_ARB_ROUND_ROBIN_EN;
// the tie-break expectations follow the macro.

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int MW = 16;

    localparam logic [DW-1:0] D_IC1  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [DW-1:0] D_IC2  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [DW-1:0] D_RST  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [DW-1:0] D_JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    localparam logic [DW-1:0] D_A    = 128'h000000AA_000000AA_000000AA_000000AA;
    localparam logic [DW-1:0] D_B    = 128'h000000BB_000000BB_000000BB_000000BB;

    logic clk;
    logic reset;
    logic busy;

    int n_checks;
    int n_fail;

    mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .MWIDTH(MW)) bus ();

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MWIDTH(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every output at its idle value.
    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},     busy,              '0);
        chk({tag, "_icrdy"},    bus.ic_req_ready,  '0);
        chk({tag, "_dcrdy"},    bus.dc_req_ready,  '0);
        chk({tag, "_mvalid"},   bus.mem_req_valid, '0);
        chk({tag, "_mrw"},      bus.mem_req_rw,    '0);
        chk({tag, "_maddr"},    bus.mem_req_addr,  '0);
        chk({tag, "_mwdata"},   bus.mem_req_wdata, '0);
        chk({tag, "_mwmask"},   bus.mem_req_wmask, '0);
        chk({tag, "_icrv"},     bus.ic_resp_valid, '0);
        chk({tag, "_dcrv"},     bus.dc_resp_valid, '0);
        chk({tag, "_icrdata"},  bus.ic_resp_data,  '0);
        chk({tag, "_dcrdata"},  bus.dc_resp_data,  '0);
    endtask

    initial begin
        logic exp_dc;
        n_checks = 0;
        n_fail   = 0;

        reset              = 1'b0;
        bus.ic_req_valid   = 1'b0;
        bus.ic_req_addr    = '0;
        bus.dc_req_valid   = 1'b0;
        bus.dc_req_rw      = 1'b0;
        bus.dc_req_addr    = '0;
        bus.dc_req_wdata   = '0;
        bus.dc_req_wmask   = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        cyc();
        cyc();
        chk_quiet("reset");
        reset = 1'b1;
        cyc();

        // Single I-cache read
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_1000;
        cyc();
        chk("ic1_icrdy",  bus.ic_req_ready, 1'b1);
        chk("ic1_dcrdy",  bus.dc_req_ready, 1'b0);
        chk("ic1_mvalid0", bus.mem_req_valid, 1'b0);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.ic_req_valid = 1'b0;
        chk("ic1_mvalid", bus.mem_req_valid, 1'b1);
        chk("ic1_maddr",  bus.mem_req_addr, 32'h0000_1000);
        chk("ic1_mrw",    bus.mem_req_rw, 1'b0);
        chk("ic1_mwmask", bus.mem_req_wmask, '0);
        chk("ic1_icrdy2", bus.ic_req_ready, 1'b0);
        chk("ic1_busy",   busy, 1'b1);
        cyc();
        bus.mem_req_ready = 1'b0;
        chk("ic1_wait_mvalid", bus.mem_req_valid, 1'b0);
        chk("ic1_wait_busy",   busy, 1'b1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_IC1;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("ic1_icrv",    bus.ic_resp_valid, 1'b1);
        chk("ic1_dcrv",    bus.dc_resp_valid, 1'b0);
        chk("ic1_icrdata", bus.ic_resp_data, D_IC1);
        chk("ic1_dcrdata", bus.dc_resp_data, D_IC1);
        cyc();
        chk("ic1_icrv_end", bus.ic_resp_valid, 1'b0);
        chk("ic1_busy_end", busy, 1'b0);

        // D-cache write, memory stalls 4 cycles
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b1;
        bus.dc_req_addr  = 32'h1000_0040;
        bus.dc_req_wdata = 128'h12345678;
        bus.dc_req_wmask = 16'h000F;
        cyc();
        chk("dcw_dcrdy", bus.dc_req_ready, 1'b1);
        chk("dcw_icrdy", bus.ic_req_ready, 1'b0);
        cyc();
        bus.dc_req_valid = 1'b0;
        bus.dc_req_addr  = 32'hFFFF_FFFF;
        bus.dc_req_wdata = D_JUNK;
        bus.dc_req_wmask = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            bus.mem_req_ready = (i == 4);
            chk("dcw_mvalid", bus.mem_req_valid, 1'b1);
            chk("dcw_mrw",    bus.mem_req_rw, 1'b1);
            chk("dcw_maddr",  bus.mem_req_addr, 32'h1000_0040);
            chk("dcw_mwdata", bus.mem_req_wdata, 128'h12345678);
            chk("dcw_mwmask", bus.mem_req_wmask, 16'h000F);
            chk("dcw_dcrv",   bus.dc_resp_valid, 1'b0);
            cyc();
        end
        bus.mem_req_ready = 1'b0;
        chk("dcw_busy_end", busy, 1'b0);
        chk("dcw_mvalid_end", bus.mem_req_valid, 1'b0);
        chk("dcw_dcrv_end", bus.dc_resp_valid, 1'b0);
        chk("dcw_icrv_end", bus.ic_resp_valid, 1'b0);

        // Spurious memory response in IDLE
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_JUNK;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("spi_busy", busy, 1'b0);
        chk("spi_icrv", bus.ic_resp_valid, 1'b0);
        chk("spi_dcrv", bus.dc_resp_valid, 1'b0);

        // Spurious memory response in ISSUE, then complete the read
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_2000;
        cyc();
        chk("sps_icrdy", bus.ic_req_ready, 1'b1);
        cyc();
        bus.ic_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_JUNK;
        chk("sps_mvalid", bus.mem_req_valid, 1'b1);
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("sps_mvalid2", bus.mem_req_valid, 1'b1);
        chk("sps_maddr",   bus.mem_req_addr, 32'h0000_2000);
        chk("sps_icrv",    bus.ic_resp_valid, 1'b0);
        chk("sps_dcrv",    bus.dc_resp_valid, 1'b0);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_IC2;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("sps_icrv_resp",  bus.ic_resp_valid, 1'b1);
        chk("sps_icrdata",    bus.ic_resp_data, D_IC2);
        cyc();

        // Requester withdraws before the handshake completes
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 32'h0000_0300;
        cyc();
        bus.dc_req_valid = 1'b0;
        cyc();
        chk("drop_busy",   busy, 1'b0);
        chk("drop_mvalid", bus.mem_req_valid, 1'b0);
        chk("drop_dcrdy",  bus.dc_req_ready, 1'b0);

        // Reset while waiting for read data
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 32'h0000_0500;
        cyc();
        chk("rst_dcrdy", bus.dc_req_ready, 1'b1);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.dc_req_valid = 1'b0;
        chk("rst_maddr", bus.mem_req_addr, 32'h0000_0500);
        cyc();
        bus.mem_req_ready = 1'b0;
        chk("rst_wait_busy", busy, 1'b1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk_quiet("rst_after");
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_JUNK;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("rst_late_dcrv", bus.dc_resp_valid, 1'b0);
        chk("rst_late_busy", busy, 1'b0);
        cyc();
        chk("rst_late_busy2", busy, 1'b0);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 32'h0000_0600;
        cyc();
        chk("rst_next_icrdy", bus.ic_req_ready, 1'b1);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.ic_req_valid = 1'b0;
        chk("rst_next_maddr", bus.mem_req_addr, 32'h0000_0600);
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_RST;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("rst_next_icrv",    bus.ic_resp_valid, 1'b1);
        chk("rst_next_icrdata", bus.ic_resp_data, D_RST);
        cyc();

        // Fresh reset so the tie-break pointer starts from the I-cache
        reset = 1'b0;
        cyc();
        reset = 1'b1;

        // Both ports requesting continuously for 4 reads
        bus.ic_req_valid  = 1'b1;
        bus.ic_req_addr   = 32'h0000_3000;
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_rw     = 1'b0;
        bus.dc_req_addr   = 32'h0000_4000;
        bus.mem_req_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_dc = (t % 2 == 1);
`else
            exp_dc = 1'b1;
`endif
            cyc();
            chk("tie_grant", {bus.ic_req_ready, bus.dc_req_ready}, exp_dc ? 2'b01 : 2'b10);
            cyc();
            chk("tie_maddr", bus.mem_req_addr, exp_dc ? 32'h0000_4000 : 32'h0000_3000);
            cyc();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'(t + 1);
            cyc();
            bus.mem_resp_valid = 1'b0;
            chk("tie_icrv",  bus.ic_resp_valid, !exp_dc);
            chk("tie_dcrv",  bus.dc_resp_valid, exp_dc);
            chk("tie_rdata", exp_dc ? bus.dc_resp_data : bus.ic_resp_data, 128'(t + 1));
        end
        bus.ic_req_valid  = 1'b0;
        bus.dc_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b0;
        cyc();
        chk("tie_busy_end", busy, 1'b0);

        // Back-to-back D-cache reads, 1-cycle memory latency
        bus.dc_req_valid  = 1'b1;
        bus.dc_req_rw     = 1'b0;
        bus.dc_req_addr   = 32'h0000_0100;
        bus.mem_req_ready = 1'b1;
        cyc();
        chk("b2b_dcrdy1", bus.dc_req_ready, 1'b1);
        cyc();
        bus.dc_req_addr = 32'h0000_0110;
        chk("b2b_maddr1", bus.mem_req_addr, 32'h0000_0100);
        cyc();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_A;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("b2b_dcrv1",    bus.dc_resp_valid, 1'b1);
        chk("b2b_dcrdata1", bus.dc_resp_data, D_A);
        chk("b2b_dcrdy_in_resp", bus.dc_req_ready, 1'b0);
        cyc();
        chk("b2b_dcrdy2", bus.dc_req_ready, 1'b1);
        chk("b2b_dcrv_gap", bus.dc_resp_valid, 1'b0);
        cyc();
        bus.dc_req_valid = 1'b0;
        chk("b2b_maddr2", bus.mem_req_addr, 32'h0000_0110);
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = D_B;
        cyc();
        bus.mem_resp_valid = 1'b0;
        chk("b2b_dcrv2",    bus.dc_resp_valid, 1'b1);
        chk("b2b_dcrdata2", bus.dc_resp_data, D_B);
        cyc();
        chk("b2b_busy_end", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single main-memory request channel between the instruction-cache refill port and the data-cache refill/writeback port. It sits between the two caches, which drive the core's `stall`, and the off-chip memory interface. It accepts one transaction at a time and registers it toward memory. Read data is returned only to the requester that issued the read.

## Interface
Parameters:
- `AWIDTH`, 32: byte address width.
- `DWIDTH`, 128: memory beat/line width.
- `MWIDTH`, 16: write byte-mask width (`DWIDTH/8`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; the block is in reset while `reset==0`.
- `ic_req_valid` in 1: I-cache request valid. Always a read.
- `ic_req_ready` out 1: I-cache request accepted this cycle.
- `ic_req_addr` in AWIDTH: I-cache read address.
- `ic_resp_valid` out 1: I-cache read data valid, one-cycle pulse.
- `ic_resp_data` out DWIDTH: I-cache read data.
- `dc_req_valid` in 1: D-cache request valid.
- `dc_req_ready` out 1: D-cache request accepted this cycle.
- `dc_req_rw` in 1: 1 = write, 0 = read.
- `dc_req_addr` in AWIDTH: D-cache address.
- `dc_req_wdata` in DWIDTH: write data.
- `dc_req_wmask` in MWIDTH: write byte mask.
- `dc_resp_valid` out 1: D-cache read data valid, one-cycle pulse.
- `dc_resp_data` out DWIDTH: D-cache read data.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_rw` out 1: memory request type.
- `mem_req_addr` out AWIDTH: memory address.
- `mem_req_wdata` out DWIDTH: memory write data.
- `mem_req_wmask` out MWIDTH: memory write mask.
- `mem_resp_valid` in 1: memory read data valid.
- `mem_resp_data` in DWIDTH: memory read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE
  - ISSUE: `mem_req_valid` is high; waiting for `mem_req_ready`.
  - WAIT: read issued; waiting for `mem_resp_valid`.
  - RESP: one cycle that drives the owner's `*_resp_valid`.
- IDLE, arbitration:
  - If exactly one requester is valid, grant it.
  - If both are valid, use the arbitration policy in Configuration.
  - On grant, pulse the winner's `*_req_ready` for one cycle. This is the request handshake.
  - Capture addr, rw (forced 0 for the I-cache), wdata and wmask (forced 0 for the I-cache) into registers.
  - Record the owner bit (0 = I-cache, 1 = D-cache), then move to ISSUE.
- ISSUE:
  - Drive `mem_req_*` from the captured registers, held stable until `mem_req_ready`.
  - On `mem_req_valid & mem_req_ready`: a write goes to IDLE; a read goes to WAIT.
- WAIT: on `mem_resp_valid`, capture `mem_resp_data` into the response register and move to RESP.
- RESP:
  - Assert only the owner's `*_resp_valid` for exactly one cycle. Both `*_resp_data` outputs carry the captured register.
  - Return to IDLE.
- Writes produce no response pulse. Write completion is the `mem_req_ready` handshake.
- Boundary conditions:
  - `mem_resp_valid` outside WAIT is ignored.
  - `*_req_ready` is never asserted outside IDLE.
  - A requester that drops valid before being granted is never granted.
  - Reset (`reset==0`) in any state goes to IDLE. Any in-flight transaction is abandoned, no response is delivered, and the round-robin pointer is cleared.

## Timing
- Reset values: all outputs 0, state IDLE, owner 0, round-robin pointer 0 (I-cache favoured first).
- All outputs are driven from registers or the state bits; no input-to-output combinational path.
- Minimum latencies:
  - Request accept cycle T (ready pulse), `mem_req_valid` at T+1.
  - With `mem_req_ready` at T+1 and `mem_resp_valid` at T+2, the owner's `resp_valid` is at T+3.
  - A write with immediate `mem_req_ready` occupies the block for 2 cycles.
  - The next grant is possible in the cycle after RESP (read) or after the ISSUE handshake (write).
- One transaction outstanding at most; no pipelining across requests.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin between the two ports.
  - The pointer flips to the other port after each grant. On a tie, the port the pointer indicates wins.
- Undefined: fixed priority. The D-cache wins every tie; the pointer register is absent.

## Test plan
- Single I-cache read:
  - Stimulus: addr 0x0000_1000; memory ready immediately; data 0xDEADBEEF_... returned 3 cycles later.
  - Response: `ic_resp_valid` pulses once with that data; `dc_resp_valid` stays 0.
- D-cache write:
  - Stimulus: addr 0x1000_0040, wmask 0x000F, wdata 0x12345678; `mem_req_ready` held low for 4 cycles.
  - Response: `mem_req_*` stable for all 5 ISSUE cycles; no response pulse; `busy` low after the handshake.
- Simultaneous requests, both ports valid continuously for 4 transactions:
  - Round-robin build: grant order IC, DC, IC, DC.
  - Fixed-priority build: the first 4 grants all go to DC.
- Spurious response: `mem_resp_valid` pulsed in IDLE and in ISSUE -> no `*_resp_valid` and no state change.
- Reset mid-operation:
  - Stimulus: `reset=0` for 1 cycle while in WAIT.
  - Response: next cycle all outputs 0, state IDLE; a later `mem_resp_valid` is ignored; the next request is served normally.
- Back-to-back reads from the D-cache (addrs 0x100, 0x110) with 1-cycle memory latency -> the second `dc_req_ready` arrives the cycle after the first `dc_resp_valid`; the data ordering is preserved.
